// File: rtl/serial_op_pkg.sv
// Shared types and helpers for the serial operand engine: FSM states, command
// encodings, ALU op indices and the 2x4 grid walk.
package serial_op_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      EXEC  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      LEFT   = 2'd0,
      STAY   = 2'd1,
      TOGGLE = 2'd2,
      RIGHT  = 2'd3
   } cmd_t;

   localparam logic [2:0] OP_AND_OR      = 3'd0;
   localparam logic [2:0] OP_XOR_ADD     = 3'd1;
   localparam logic [2:0] OP_ABSDIFF_XOR = 3'd2;
   localparam logic [2:0] OP_MIN_LOW     = 3'd3;
   localparam logic [2:0] OP_MAX_ADD     = 3'd4;
   localparam logic [2:0] OP_SAT_AND     = 3'd5;
   localparam logic [2:0] OP_AVG_OR      = 3'd6;
   localparam logic [2:0] OP_ROT_XOR     = 3'd7;

   // Bit 2 selects the row; left/right saturate at the row ends instead of wrapping.
   function automatic logic [2:0] next_op(input logic [2:0] cur, input cmd_t cmd);
      logic [2:0] nxt;
      nxt = cur;
      case (cmd)
         LEFT:    if (cur[1:0] != 2'd0) nxt = cur - 3'd1;
         TOGGLE:  nxt = cur ^ 3'b100;
         RIGHT:   if (cur[1:0] != 2'd3) nxt = cur + 3'd1;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/op_alu.sv
// Eight-way combinational ALU folding operands a/b into accumulator value c.
module op_alu
   import serial_op_pkg::*;
#(
   parameter int N = 64
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic [2:0]   sel,
   output logic [N-1:0] res
);

   logic [N:0]   sum;
   logic [N-1:0] mx;
   logic [N-1:0] mn;
   logic [N-1:0] sat_sum;

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      mx      = (a > b) ? a : b;
      mn      = (a > b) ? b : a;
      sat_sum = sum[N] ? {N{1'b1}} : sum[N-1:0];
      res     = '0;
      case (sel)
         OP_AND_OR:      res = (a & b) | c;
         OP_XOR_ADD:     res = (a ^ b) + c;
         OP_ABSDIFF_XOR: res = (mx - mn) ^ c;
         OP_MIN_LOW:     res = {c[N-1:N/2], mn[N/2-1:0]};
         OP_MAX_ADD:     res = mx + (c << 1);
         OP_SAT_AND:     res = sat_sum & c;
         // Overflow-free floor average of a and b.
         OP_AVG_OR:      res = ((a & b) + ((a ^ b) >> 1)) | c;
         OP_ROT_XOR:     res = {a[N-2:0], a[N-1]} ^ b ^ c;
         default:        res = '0;
      endcase
   end

endmodule

// File: rtl/serial_op_engine.sv
// Chunked operand loader, command-driven ALU grid walker and chunked result
// drain. Handshakes complete on valid & ready at posedge clk; ready is gated by abort.
module serial_op_engine
   import serial_op_pkg::*;
#(
   parameter int N        = 64,
   parameter int W        = 4,
   parameter int ACC_KEEP = 0,
   parameter int STEP_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      a_in,
   input  logic [W-1:0]      b_in,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic              out_last,
   output logic [2:0]        cur_op,
   output logic [STEP_W-1:0] step_count,
   output logic              busy
);

   localparam int NCH = N / W;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

   if ((N % W) != 0 || (N / W) < 2) begin : g_bad_params
      $error("serial_op_engine: N must be a multiple of W with N/W >= 2");
   end

   state_t        state;
   logic [N-1:0]  a_reg;
   logic [N-1:0]  b_reg;
   logic [N-1:0]  acc;
   logic [CW-1:0] chunk_cnt;
   logic [2:0]    nxt;
   logic [N-1:0]  alu_res;

   assign in_ready  = (state == LOAD) && !abort;
   assign cmd_ready = (state == EXEC) && !abort;
   assign busy      = (state != IDLE);
   assign out_data  = out_valid ? acc[int'(chunk_cnt)*W +: W] : '0;
   assign out_last  = out_valid && (chunk_cnt == LAST_CHUNK);
   assign nxt       = next_op(cur_op, cmd_t'(cmd_op));

   op_alu #(.N(N)) u_alu (
      .a   (a_reg),
      .b   (b_reg),
      .c   (acc),
      .sel (nxt),
      .res (alu_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         acc        <= '0;
         chunk_cnt  <= '0;
         cur_op     <= '0;
         step_count <= '0;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= LOAD;
                  a_reg      <= '0;
                  b_reg      <= '0;
                  chunk_cnt  <= '0;
                  cur_op     <= '0;
                  step_count <= '0;
                  if (ACC_KEEP == 0) acc <= '0;
               end
            end
            LOAD: begin
               if (abort) begin
                  state     <= IDLE;
                  chunk_cnt <= '0;
               end else if (in_valid) begin
                  a_reg[int'(chunk_cnt)*W +: W] <= a_in;
                  b_reg[int'(chunk_cnt)*W +: W] <= b_in;
                  if (chunk_cnt == LAST_CHUNK) begin
                     state     <= EXEC;
                     chunk_cnt <= '0;
                  end else begin
                     chunk_cnt <= chunk_cnt + 1'b1;
                  end
               end
            end
            EXEC: begin
               if (abort) begin
                  state <= IDLE;
               end else if (cmd_valid) begin
                  cur_op <= nxt;
                  acc    <= alu_res;
                  if (step_count != {STEP_W{1'b1}}) step_count <= step_count + 1'b1;
                  if (cmd_last) begin
                     state     <= DRAIN;
                     chunk_cnt <= '0;
                     out_valid <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  state     <= IDLE;
                  chunk_cnt <= '0;
                  out_valid <= 1'b0;
               end else if (out_ready) begin
                  if (chunk_cnt == LAST_CHUNK) begin
                     state     <= IDLE;
                     chunk_cnt <= '0;
                     out_valid <= 1'b0;
                  end else begin
                     chunk_cnt <= chunk_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_op_engine.sv
// Directed bench for serial_op_engine at N=16, W=4; a second instance with
// ACC_KEEP=1 shares all inputs to show accumulator carry-over between jobs.
module tb_serial_op_engine;
   import serial_op_pkg::*;

   localparam int N   = 16;
   localparam int W   = 4;
   localparam int NCH = N / W;

   logic          clk = 1'b0;
   logic          rst, start, abort, in_valid, cmd_valid, cmd_last, out_ready;
   logic [W-1:0]  a_in, b_in;
   logic [1:0]    cmd_op;
   logic          in_ready, cmd_ready, out_valid, out_last, busy;
   logic [W-1:0]  out_data;
   logic [2:0]    cur_op;
   logic [7:0]    step_count;
   logic          k_in_ready, k_cmd_ready, k_out_valid, k_out_last, k_busy;
   logic [W-1:0]  k_out_data;
   logic [2:0]    k_cur_op;
   logic [7:0]    k_step_count;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0]   cmd;
      logic         last;
      logic [2:0]   op;
      logic [N-1:0] acc;
   } vec_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           first;
      int           count;
   } job_t;

   vec_t         vecs[20];
   job_t         jobs[5];
   logic [W-1:0] exp_q[$];

   serial_op_engine #(.N(N), .W(W), .ACC_KEEP(0), .STEP_W(8)) dut0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_last(cmd_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .cur_op(cur_op), .step_count(step_count), .busy(busy)
   );

   serial_op_engine #(.N(N), .W(W), .ACC_KEEP(1), .STEP_W(8)) dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(k_in_ready), .a_in(a_in), .b_in(b_in),
      .cmd_valid(cmd_valid), .cmd_ready(k_cmd_ready), .cmd_op(cmd_op), .cmd_last(cmd_last),
      .out_valid(k_out_valid), .out_ready(out_ready), .out_data(k_out_data), .out_last(k_out_last),
      .cur_op(k_cur_op), .step_count(k_step_count), .busy(k_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_in_ready();
      int n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_cmd_ready();
      int n = 0;
      while (!cmd_ready && n < 20) begin tick(); n++; end
      if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_out_valid();
      int n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_job();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load(input logic [N-1:0] a, input logic [N-1:0] b, input bit gap);
      for (int i = 0; i < NCH; i++) begin
         if (gap && i == 2) begin
            in_valid = 1'b0;
            repeat (2) begin
               tick();
               chk("load_hold_cnt", 32'(dut0.chunk_cnt), 32'd2);
            end
         end
         in_valid = 1'b1;
         a_in     = a[i*W +: W];
         b_in     = b[i*W +: W];
         wait_in_ready();
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic send_cmd(input vec_t v);
      cmd_valid = 1'b1;
      cmd_op    = v.cmd;
      cmd_last  = v.last;
      wait_cmd_ready();
      tick();
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
      chk("cur_op", 32'(cur_op), 32'(v.op));
      chk("acc", 32'(dut0.acc), 32'(v.acc));
   endtask

   task automatic drain(input bit stall);
      logic [W-1:0] exp;
      for (int i = 0; i < NCH; i++) begin
         wait_out_valid();
         if (stall && i == 2) begin
            repeat (3) begin
               tick();
               chk("stall_data", 32'(out_data), 32'(exp_q[0]));
               chk("stall_valid", 32'(out_valid), 32'd1);
            end
         end
         exp = exp_q.pop_front();
         chk("drain_data", 32'(out_data), 32'(exp));
         chk("drain_last", 32'(out_last), (i == NCH - 1) ? 32'd1 : 32'd0);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      chk("drain_done_busy", 32'(busy), 32'd0);
      chk("drain_done_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic run_job(input int j, input bit gap, input bit stall);
      logic [N-1:0] final_acc;
      start_job();
      load(jobs[j].a, jobs[j].b, gap);
      for (int k = 0; k < jobs[j].count; k++) send_cmd(vecs[jobs[j].first + k]);
      final_acc = vecs[jobs[j].first + jobs[j].count - 1].acc;
      for (int i = 0; i < NCH; i++) exp_q.push_back(final_acc[i*W +: W]);
      drain(stall);
      chk("step_count", 32'(step_count), 32'(jobs[j].count));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_last"}, 32'(out_last), 32'd0);
      chk({tag, "_out_data"}, 32'(out_data), 32'd0);
      chk({tag, "_cur_op"}, 32'(cur_op), 32'd0);
      chk({tag, "_step_count"}, 32'(step_count), 32'd0);
      chk({tag, "_acc"}, 32'(dut0.acc), 32'd0);
      chk({tag, "_keep_acc"}, 32'(dut1.acc), 32'd0);
   endtask

   initial begin
      // Basic job, ACC_KEEP follow-up, saturation, grid walk, post-abort job.
      vecs[0]  = '{STAY,   1'b0, 3'd0, 16'h0034};
      vecs[1]  = '{RIGHT,  1'b1, 3'd1, 16'h12FF};
      vecs[2]  = '{STAY,   1'b1, 3'd0, 16'h0034};
      vecs[3]  = '{TOGGLE, 1'b0, 3'd4, 16'hFFFF};
      vecs[4]  = '{RIGHT,  1'b1, 3'd5, 16'hFFFF};
      vecs[5]  = '{LEFT,   1'b0, 3'd0, 16'h0001};
      vecs[6]  = '{RIGHT,  1'b0, 3'd1, 16'h0007};
      vecs[7]  = '{RIGHT,  1'b0, 3'd2, 16'h0005};
      vecs[8]  = '{RIGHT,  1'b0, 3'd3, 16'h0003};
      vecs[9]  = '{RIGHT,  1'b0, 3'd3, 16'h0003};
      vecs[10] = '{TOGGLE, 1'b0, 3'd7, 16'h0000};
      vecs[11] = '{LEFT,   1'b0, 3'd6, 16'h0004};
      vecs[12] = '{LEFT,   1'b0, 3'd5, 16'h0000};
      vecs[13] = '{LEFT,   1'b0, 3'd4, 16'h0005};
      vecs[14] = '{LEFT,   1'b0, 3'd4, 16'h000F};
      vecs[15] = '{RIGHT,  1'b0, 3'd5, 16'h0008};
      vecs[16] = '{RIGHT,  1'b0, 3'd6, 16'h000C};
      vecs[17] = '{RIGHT,  1'b0, 3'd7, 16'h000F};
      vecs[18] = '{TOGGLE, 1'b1, 3'd3, 16'h0003};
      vecs[19] = '{STAY,   1'b1, 3'd0, 16'h0248};
      jobs[0]  = '{16'h1234, 16'h00FF, 0, 2};
      jobs[1]  = '{16'h1234, 16'h00FF, 2, 1};
      jobs[2]  = '{16'hFFFF, 16'h0001, 3, 2};
      jobs[3]  = '{16'h0003, 16'h0005, 5, 14};
      jobs[4]  = '{16'hABCD, 16'h5678, 19, 1};

      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; cmd_valid = 1'b0;
      cmd_last = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; cmd_op = '0;
      repeat (2) tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick();

      run_job(0, 1'b0, 1'b0);
      chk("keep_first_acc", 32'(dut1.acc), 32'h12FF);
      run_job(1, 1'b0, 1'b0);
      chk("keep_second_acc", 32'(dut1.acc), 32'h12FF);
      run_job(2, 1'b0, 1'b0);
      run_job(3, 1'b0, 1'b0);
      run_job(0, 1'b1, 1'b1);

      // Abort on the third operand chunk: nothing accepted, back to IDLE.
      start_job();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         a_in = 4'h9;
         b_in = 4'h6;
         tick();
      end
      abort = 1'b1;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      tick();
      abort = 1'b0;
      in_valid = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      tick();
      chk("abort_idle_out_valid", 32'(out_valid), 32'd0);
      run_job(4, 1'b0, 1'b0);

      // Reset in the middle of EXEC.
      start_job();
      load(16'h1234, 16'h00FF, 1'b0);
      send_cmd(vecs[0]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_outputs("mid_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
